// File: rtl/bus_arbiter8.sv
// Eight-way round-robin bus arbiter with bounded burst tenure.
// The owner streams its 16-bit word onto y until it drops req or hits BURST_MAX.
module bus_arbiter8 #(
  parameter int unsigned BURST_MAX = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   req,
  input  logic [127:0] data,
  output logic [7:0]   gnt,
  output logic [2:0]   sel,
  output logic [15:0]  y,
  output logic         y_valid,
  output logic         busy
);

  typedef enum logic {
    IDLE,
    OWN
  } state_t;

  localparam logic [3:0] BMAX = 4'(BURST_MAX);

  state_t      state;
  logic [2:0]  ptr;
  logic [3:0]  cnt;

  logic        arb_hit;
  logic [2:0]  arb_idx;
  logic [2:0]  scan;
  logic        own_req;
  logic        last;
  logic        rel;
  logic [15:0] slice;

  // Walk from the farthest offset back to ptr so the nearest hit wins.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = ptr;
    scan    = ptr;
    for (int k = 7; k >= 0; k--) begin
      scan = ptr + 3'(k);
      if (req[scan]) begin
        arb_hit = 1'b1;
        arb_idx = scan;
      end
    end
  end

  assign own_req = req[sel];
  assign last    = (cnt + 4'd1) == BMAX;
  assign rel     = !own_req || last;
  assign slice   = data[{sel, 4'b0000} +: 16];
  assign busy    = |gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 3'd0;
      cnt     <= 4'd0;
      gnt     <= 8'h00;
      sel     <= 3'd0;
      y       <= 16'h0000;
      y_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          y_valid <= 1'b0;
          if (arb_hit) begin
            gnt   <= 8'h01 << arb_idx;
            sel   <= arb_idx;
            ptr   <= arb_idx + 3'd1;
            cnt   <= 4'd0;
            state <= OWN;
          end else begin
            gnt <= 8'h00;
          end
        end
        OWN: begin
          if (own_req) begin
            y       <= slice;
            y_valid <= 1'b1;
            cnt     <= cnt + 4'd1;
          end else begin
            y_valid <= 1'b0;
          end
          // Re-arbitrate on the releasing edge; ptr already skips the owner.
          if (rel) begin
            if (arb_hit) begin
              gnt   <= 8'h01 << arb_idx;
              sel   <= arb_idx;
              ptr   <= arb_idx + 3'd1;
              cnt   <= 4'd0;
              state <= OWN;
            end else begin
              gnt   <= 8'h00;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter8.sv
// Directed bench for bus_arbiter8.
// Stimulus queues expected y words; a negedge monitor pops them on y_valid.
module tb_bus_arbiter8;

  logic         clk;
  logic         rst_n;
  logic [7:0]   req;
  logic [127:0] data;
  logic [7:0]   gnt;
  logic [2:0]   sel;
  logic [15:0]  y;
  logic         y_valid;
  logic         busy;

  int total;
  int bad;
  logic [15:0] exp_q[$];

  bus_arbiter8 #(.BURST_MAX(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .data(data),
    .gnt(gnt),
    .sel(sel),
    .y(y),
    .y_valid(y_valid),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && y_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL y_extra: got %0h want no word at %0t", y, $time);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (y !== e) begin
          bad++;
          $display("FAIL y_word: got %0h want %0h at %0t", y, e, $time);
        end
      end
    end
  end

  task automatic set_slice(input int i, input logic [15:0] w);
    data[16*i +: 16] = w;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_gnt"}, 32'(gnt), 32'h0);
    chk({name, "_sel"}, 32'(sel), 32'h0);
    chk({name, "_y"}, 32'(y), 32'h0);
    chk({name, "_yv"}, 32'(y_valid), 32'h0);
    chk({name, "_busy"}, 32'(busy), 32'h0);
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task automatic do_reset(input string name);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero(name);
    @(negedge clk);
    req = 8'h00;
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    chk({name, "_qleft"}, 32'(exp_q.size()), 32'h0);
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] eg;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    req   = 8'h00;
    data  = '0;
    #1 chk_zero("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Idle bus for 20 cycles.
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (n % 5 == 0) chk_zero("idle");
    end

    // Sole requester 3: no gnt or y_valid gap across tenures.
    set_slice(3, 16'h1234);
    req = 8'h08;
    for (int n = 2; n <= 10; n++) exp_q.push_back(16'h1234);
    @(negedge clk);
    chk("sole_gnt1", 32'(gnt), 32'h08);
    chk("sole_yv1", 32'(y_valid), 32'h0);
    chk("sole_sel", 32'(sel), 32'h3);
    for (int n = 2; n <= 10; n++) begin
      @(negedge clk);
      chk("sole_gnt", 32'(gnt), 32'h08);
      chk("sole_yv", 32'(y_valid), 32'h1);
    end
    req = 8'h00;
    @(negedge clk);
    chk("sole_end_gnt", 32'(gnt), 32'h0);
    chk("sole_end_yv", 32'(y_valid), 32'h0);
    chk("sole_end_y", 32'(y), 32'h1234);
    chk("sole_end_sel", 32'(sel), 32'h3);
    drain("sole");

    // All eight requesting from reset: 4-cycle tenures in rotation.
    do_reset("rst_a");
    for (int i = 0; i < 8; i++) set_slice(i, 16'hA000 + 16'(i));
    req = 8'hFF;
    for (int n = 2; n <= 34; n++)
      exp_q.push_back(16'hA000 + 16'(((n - 2) / 4) % 8));
    for (int n = 1; n <= 34; n++) begin
      @(negedge clk);
      eg = 8'h01 << (((n - 1) / 4) % 8);
      chk("rr_gnt", 32'(gnt), 32'(eg));
      if (n % 4 == 1) chk("rr_sel", 32'(sel), 32'(((n - 1) / 4) % 8));
    end
    req = 8'h00;
    @(negedge clk);
    chk("rr_end_busy", 32'(busy), 32'h0);
    drain("rr");

    // Requester 7 tenure, pointer wraps to 0, then back to 7.
    do_reset("rst_b");
    for (int i = 0; i < 8; i++) set_slice(i, 16'hB000 + 16'(i));
    req = 8'h80;
    for (int n = 0; n < 4; n++) exp_q.push_back(16'hB007);
    for (int n = 0; n < 4; n++) exp_q.push_back(16'hB000);
    @(negedge clk);
    chk("wrap_gnt7", 32'(gnt), 32'h80);
    repeat (3) @(negedge clk);
    req = 8'h81;
    @(negedge clk);
    chk("wrap_gnt0", 32'(gnt), 32'h01);
    chk("wrap_sel0", 32'(sel), 32'h0);
    repeat (4) @(negedge clk);
    chk("wrap_gnt7b", 32'(gnt), 32'h80);
    chk("wrap_sel7", 32'(sel), 32'h7);
    req = 8'h00;
    @(negedge clk);
    chk("wrap_end", 32'(gnt), 32'h0);
    drain("wrap");

    // Owner 2 drops after one word while 5 is waiting.
    do_reset("rst_c");
    set_slice(2, 16'hC222);
    set_slice(5, 16'hC555);
    req = 8'h04;
    exp_q.push_back(16'hC222);
    exp_q.push_back(16'hC555);
    @(negedge clk);
    chk("drop_gnt2", 32'(gnt), 32'h04);
    req = 8'h24;
    @(negedge clk);
    chk("drop_gnt2b", 32'(gnt), 32'h04);
    req = 8'h20;
    @(negedge clk);
    chk("drop_gnt5", 32'(gnt), 32'h20);
    chk("drop_yv", 32'(y_valid), 32'h0);
    chk("drop_y", 32'(y), 32'hC222);
    @(negedge clk);
    req = 8'h00;
    @(negedge clk);
    chk("drop_busy", 32'(busy), 32'h0);
    chk("drop_yhold", 32'(y), 32'hC555);
    chk("drop_selhold", 32'(sel), 32'h5);
    drain("drop");

    // Reset mid-burst, then req=06 must start from ptr 0.
    do_reset("rst_d");
    set_slice(1, 16'hD111);
    set_slice(2, 16'hD222);
    req = 8'h02;
    exp_q.push_back(16'hD111);
    @(negedge clk);
    chk("mid_gnt", 32'(gnt), 32'h02);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("mid_rst");
    @(negedge clk);
    chk_zero("mid_hold");
    rst_n = 1'b1;
    req = 8'h06;
    @(negedge clk);
    chk("post_gnt", 32'(gnt), 32'h02);
    chk("post_sel", 32'(sel), 32'h1);
    chk("post_yv", 32'(y_valid), 32'h0);
    req = 8'h00;
    @(negedge clk);
    chk("post_idle", 32'(busy), 32'h0);
    drain("mid");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
